// File: rtl/cnn_window_gen.sv
// rtl/cnn_window_gen.sv - streaming KYxKX sliding-window generator, stride 1, no padding
module cnn_window_gen #(
    parameter int CI    = 3,
    parameter int KX    = 5,
    parameter int KY    = 5,
    parameter int IBW   = 8,
    parameter int IMG_W = 12,
    parameter int IMG_H = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_in_valid,
    input  logic [CI*IBW-1:0]          i_in_pixel,
    output logic                       o_ot_valid,
    output logic [CI*KX*KY*IBW-1:0]    o_ot_fmap,
    output logic                       o_frame_done
);

    localparam int PW     = CI * IBW;
    localparam int FW     = CI * KX * KY * IBW;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int LB_LEN = (KY - 1) * IMG_W;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST_OUT = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(KY - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // One long delay chain; tap k*IMG_W-1 is the pixel k rows above at this column.
    logic [PW-1:0] lb [LB_LEN];
    logic [PW-1:0] win     [KY][KX];
    logic [PW-1:0] win_nxt [KY][KX];
    logic [FW-1:0] fmap_nxt;
    logic          win_out;
    logic          last_pix;

    always_comb begin
        win_nxt  = win;
        fmap_nxt = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
                win_nxt[ky][kx] = win[ky][kx+1];
            end
        end
        for (int ky = 0; ky < KY - 1; ky++) begin
            win_nxt[ky][KX-1] = lb[(KY - 1 - ky) * IMG_W - 1];
        end
        win_nxt[KY-1][KX-1] = i_in_pixel;
        for (int c = 0; c < CI; c++) begin
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    fmap_nxt[(c*KY*KX + ky*KX + kx)*IBW +: IBW] = win_nxt[ky][kx][c*IBW +: IBW];
                end
            end
        end
    end

    assign win_out  = i_in_valid && (row >= ROW_FIRST_OUT) && (col >= COL_FIRST_OUT);
    assign last_pix = i_in_valid && (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_ot_fmap    <= '0;
            for (int i = 0; i < LB_LEN; i++) begin
                lb[i] <= '0;
            end
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
        end else begin
            o_ot_valid   <= win_out;
            o_frame_done <= last_pix;
            if (win_out) begin
                o_ot_fmap <= fmap_nxt;
            end
            if (i_in_valid) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                lb[0] <= i_in_pixel;
                for (int i = 1; i < LB_LEN; i++) begin
                    lb[i] <= lb[i-1];
                end
                win <= win_nxt;
            end
        end
    end

endmodule
